// File: rtl/hw_regs_bank.sv
// GPU hardware control register bank: byte array with masked line writes,
// one-cycle line reads, sequenced default load after reset and write notify.
module hw_regs_bank #(
  parameter int PORT_ADDR_SIZE = 20,
  parameter int PORT_CACHE_BITS = 128,
  parameter int ENDIAN = 1,
  parameter int HW_REGS_SIZE = 14,
  parameter logic [PORT_ADDR_SIZE-1:0] BASE_WRITE_ADDRESS = '0,
  parameter int LOCK_BASE = 0,
  parameter int LOCK_SIZE = 0,
  parameter int RST_PARAM_SIZE = 2,
  parameter logic [31:0] RESET_VALUES [1:RST_PARAM_SIZE] =
    '{32'h0000_0010, 32'h0002_0010}
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         WE,
  input  logic [PORT_ADDR_SIZE-1:0]    ADDR_IN,
  input  logic [PORT_CACHE_BITS-1:0]   DATA_IN,
  input  logic [PORT_CACHE_BITS/8-1:0] WMASK,
  input  logic                         RD_REQ,
  input  logic [PORT_ADDR_SIZE-1:0]    RD_ADDR,
  output logic                         READY,
  output logic                         BUSY,
  output logic [PORT_CACHE_BITS-1:0]   DATA_OUT,
  output logic                         RD_VALID,
  output logic                         WR_NOTIFY,
  output logic [HW_REGS_SIZE-1:0]      WR_NOTIFY_ADDR,
  output logic [PORT_CACHE_BITS/8-1:0] WR_NOTIFY_MASK,
  output logic [(2**HW_REGS_SIZE)-1:0][7:0] HW_REGS
);

  localparam int NL = PORT_CACHE_BITS / 8;
  localparam int LB = $clog2(NL);
  localparam int HS = HW_REGS_SIZE;
  localparam int PA = PORT_ADDR_SIZE;
  localparam int NB = 2 ** HS;
  localparam int KW = $clog2(RST_PARAM_SIZE + 1);
  localparam bit ELO = (ENDIAN & 1) != 0;
  localparam bit LOCK_EN = LOCK_SIZE != 0;

  typedef enum logic [1:0] {
    S_RST,
    S_INIT,
    S_RUN
  } state_t;

  state_t state;
  state_t state_nx;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nx;

  logic [NB-1:0][7:0] regs;

  logic [31:0] init_ent;
  logic [HS-1:0] init_even;
  logic [HS-1:0] init_odd;

  logic wr_hit;
  logic [HS-1:0] wr_base;
  logic [HS-1:0] wr_off [NL];
  logic [NL-1:0] wr_eff;
  logic wr_any;

  logic rd_acc;
  logic rd_hit;
  logic [HS-1:0] rd_base;
  logic [PORT_CACHE_BITS-1:0] rd_line;

  logic unused;

  assign unused = ^{ADDR_IN[LB-1:0], RD_ADDR[LB-1:0],
                    init_ent[16], init_ent[31:16+HS]};

  assign HW_REGS = regs;

  function automatic logic in_lock(input logic [HS-1:0] off);
    logic [32:0] o1;
    o1 = {{(33-HS){1'b0}}, off} + 33'd1;
    return LOCK_EN &&
           (o1 > 33'(LOCK_BASE)) &&
           (o1 <= 33'(LOCK_BASE + LOCK_SIZE));
  endfunction

  always_comb begin
    state_nx = state;
    k_nx = k;
    unique case (state)
      S_RST: begin
        state_nx = S_INIT;
        k_nx = KW'(1);
      end
      S_INIT: begin
        if (k == KW'(RST_PARAM_SIZE))
          state_nx = S_RUN;
        else
          k_nx = k + KW'(1);
      end
      S_RUN: state_nx = S_RUN;
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    init_ent = '0;
    for (int j = 1; j <= RST_PARAM_SIZE; j++) begin
      if (k == KW'(j))
        init_ent = RESET_VALUES[j];
    end
    init_even = {init_ent[17 +: HS-1], 1'b0};
    init_odd  = {init_ent[17 +: HS-1], 1'b1};
  end

  // Lane i maps to byte (i ^ ENDIAN) of the line on both paths
  always_comb begin
    wr_hit = ADDR_IN[PA-1:HS] == BASE_WRITE_ADDRESS[PA-1:HS];
    wr_base = {ADDR_IN[HS-1:LB], {LB{1'b0}}};
    for (int i = 0; i < NL; i++) begin
      wr_off[i] = wr_base | HS'(i ^ ENDIAN);
      wr_eff[i] = WE && READY && wr_hit && WMASK[i] &&
                  !in_lock(wr_off[i]);
    end
    wr_any = |wr_eff;
  end

  always_comb begin
    rd_acc = RD_REQ && READY;
    rd_hit = RD_ADDR[PA-1:HS] == BASE_WRITE_ADDRESS[PA-1:HS];
    rd_base = {RD_ADDR[HS-1:LB], {LB{1'b0}}};
    for (int i = 0; i < NL; i++) begin
      rd_line[8*i +: 8] = regs[rd_base | HS'(i ^ ENDIAN)];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_RST;
      k <= '0;
      BUSY <= 1'b1;
      READY <= 1'b0;
      RD_VALID <= 1'b0;
      DATA_OUT <= '0;
      WR_NOTIFY <= 1'b0;
      WR_NOTIFY_ADDR <= '0;
      WR_NOTIFY_MASK <= '0;
    end else begin
      state <= state_nx;
      k <= k_nx;
      BUSY <= state_nx != S_RUN;
      READY <= state_nx == S_RUN;
      RD_VALID <= rd_acc;
      if (rd_acc)
        DATA_OUT <= rd_hit ? rd_line : '0;
      WR_NOTIFY <= wr_any;
      if (wr_any) begin
        WR_NOTIFY_ADDR <= wr_base;
        WR_NOTIFY_MASK <= wr_eff;
      end
    end
  end

  // Contents survive reset; only the default entries are reloaded
  always_ff @(posedge CLK) begin
    if (state == S_INIT) begin
      regs[init_even] <= ELO ? init_ent[7:0] : init_ent[15:8];
      regs[init_odd]  <= ELO ? init_ent[15:8] : init_ent[7:0];
    end
    for (int i = 0; i < NL; i++) begin
      if (wr_eff[i])
        regs[wr_off[i]] <= DATA_IN[8*i +: 8];
    end
  end

endmodule

// File: doc/hw_regs_bank.md
# hw_regs_bank

Parametrised hardware control register bank for the GPU: a byte-addressed register array exposed in parallel to the display pipeline. It accepts masked cache-line writes from the DDR3/CPU port and returns cache-line reads with a fixed one-cycle latency. It also loads its default table through a sequenced init after reset and reports every accepted write on a notify strobe. It replaces the single-write-port register block and sits at the same address window on the multi-port memory bus.

## Interface
- PORT_ADDR_SIZE, 20, byte address width of the bus port
- PORT_CACHE_BITS, 128, data width of one cache line; a multiple of 16
- ENDIAN, 1, byte-lane XOR on line offset: 0 none, 1 16-bit swap, 3 32-bit swap
- HW_REGS_SIZE, 14, log2 of array bytes
- BASE_WRITE_ADDRESS, 20'h0, window base; bits below HW_REGS_SIZE ignored
- LOCK_BASE, 0, first byte offset of the read-only region
- LOCK_SIZE, 0, byte length of the read-only region; 0 disables locking
- RST_PARAM_SIZE, 2, number of default entries
- RESET_VALUES[1:RST_PARAM_SIZE], '{{16'h00,16'h10},{16'h02,16'h10}}, each entry {byte addr[31:16], word[15:0]}; address bit 0 ignored
- CLK, in, 1, the single clock
- RESET_N, in, 1, asynchronous active-low reset
- WE, in, 1, write request
- ADDR_IN, in, PORT_ADDR_SIZE, write byte address; low log2(PORT_CACHE_BITS/8) bits ignored
- DATA_IN, in, PORT_CACHE_BITS, write data; byte lane i covers bits [8i+7:8i]
- WMASK, in, PORT_CACHE_BITS/8, byte-lane enables for DATA_IN
- RD_REQ, in, 1, read request
- RD_ADDR, in, PORT_ADDR_SIZE, read byte address; low bits ignored
- READY, out, 1, write and read requests are accepted this cycle
- BUSY, out, 1, reset or init sequence in progress
- DATA_OUT, out, PORT_CACHE_BITS, read line
- RD_VALID, out, 1, DATA_OUT is valid
- WR_NOTIFY, out, 1, one-cycle pulse per effective write
- WR_NOTIFY_ADDR, out, HW_REGS_SIZE, line base offset of the notified write
- WR_NOTIFY_MASK, out, PORT_CACHE_BITS/8, byte lanes actually written
- HW_REGS, out, 8 x 2^HW_REGS_SIZE, parallel view of the register array

## Operation
- The array is not cleared by reset. Configuration initialises it to 0. Entries outside RESET_VALUES keep their contents across resets.
- States are RST, INIT and RUN.
  - RESET_N low forces RST asynchronously.
  - On the first clock with RESET_N high the block moves to INIT with k=1.
  - INIT writes entry k each cycle. k=RST_PARAM_SIZE moves the block to RUN.
  - Reset asserted mid-INIT returns to RST, and INIT restarts from k=1 after release.
- INIT byte placement: if ENDIAN[0]=1, word[7:0] goes to the even address and word[15:8] to the odd address; otherwise the two bytes are swapped. INIT writes ignore the lock region.
- Window hit: an address hits when address[PORT_ADDR_SIZE-1:HW_REGS_SIZE] equals the same bits of BASE_WRITE_ADDRESS.
- Write accept condition: WE && READY && hit.
- Write lane mapping: lane i writes byte line_base|(i^ENDIAN), gated by WMASK[i], and is suppressed if that byte offset lies in [LOCK_BASE, LOCK_BASE+LOCK_SIZE).
- The effective mask is the lane mask after hit and lock gating. A non-zero effective mask raises WR_NOTIFY with WR_NOTIFY_ADDR and WR_NOTIFY_MASK. A zero effective mask produces no notify.
- Read accept condition: RD_REQ && READY.
  - On a hit, DATA_OUT lane i = HW_REGS[line_base|(i^ENDIAN)].
  - On a miss, DATA_OUT = 0. RD_VALID is still asserted.
- A write and a read to the same line in the same cycle: the read returns the pre-write data.

## Timing
- Reset values: BUSY=1, READY=0, RD_VALID=0, DATA_OUT=0, WR_NOTIFY=0, WR_NOTIFY_ADDR=0, WR_NOTIFY_MASK=0.
- INIT occupies exactly RST_PARAM_SIZE cycles. BUSY is high throughout RST and INIT.
- READY = !BUSY, registered. READY rises on the first RUN cycle.
- Requests with READY=0 are dropped, not queued.
- Write: the array and HW_REGS update at the accepting edge. WR_NOTIFY pulses during the following cycle.
- Read: RD_VALID and DATA_OUT are registered one cycle after the accepting edge.
  - DATA_OUT holds its value until the next accepted read.
  - RD_VALID is a single-cycle pulse per accepted read.
  - Back-to-back reads give one line per cycle.
- Notify: a write every cycle gives one WR_NOTIFY pulse per cycle, each with that write's address and mask.

## Test plan
- Release RESET_N with defaults -> BUSY high 2 cycles after the release edge, then READY=1. HW_REGS[0]=8'h10, HW_REGS[1]=8'h00, HW_REGS[2]=8'h10.
- RUN, ENDIAN=1, WE with ADDR_IN=20'h00010, DATA_IN lane0=8'hAA, lane1=8'hBB, WMASK=16'h0003 -> HW_REGS[16'h11]=8'hAA, HW_REGS[16'h10]=8'hBB. WR_NOTIFY next cycle with addr 14'h10, mask 16'h0003.
- Same write then RD_REQ at 20'h00010 -> RD_VALID one cycle later; DATA_OUT lane0=8'hAA, lane1=8'hBB; all other lanes hold prior contents.
- LOCK_BASE=16'h20, LOCK_SIZE=16, full-mask write to 20'h00020 -> array unchanged, no WR_NOTIFY. A read of 20'h40000 (miss) -> RD_VALID with DATA_OUT=0.
- Write and read of the same line in one cycle -> DATA_OUT returns the old line; a second read returns the new line.
- Assert RESET_N low mid-INIT, then release -> INIT restarts with the full RST_PARAM_SIZE cycles, and WE pulses during BUSY are ignored.
